// File: rtl/key_counter_bank_pkg.sv
// Shared types and constants for the key-controlled counter bank.
package key_counter_bank_pkg;

    // Auto-repeat state of one key.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_REPEAT = 2'd2
    } step_state_t;

    // Overflow behaviour of a counter channel.
    localparam int SAT_WRAP  = 0;
    localparam int SAT_CLAMP = 1;

    // Short timings for simulation; board builds keep the top-level defaults.
    localparam int SIM_DEBOUNCE_CYCLES = 4;
    localparam int SIM_HOLD_CYCLES     = 10;
    localparam int SIM_REPEAT_CYCLES   = 3;

    // Bits needed for a timer that counts 0 .. n-1 (never less than one bit).
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/key_counter_bank_key_step_gen.sv
// One raw active-low key -> synchronised, debounced, auto-repeating step pulse.
module key_step_gen
    import key_counter_bank_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50_000,
    parameter int HOLD_CYCLES     = 25_000_000,
    parameter int REPEAT_CYCLES   = 5_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic step
);

    localparam int DB_W  = cnt_width(DEBOUNCE_CYCLES);
    localparam int TMR_N = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TMR_W = cnt_width(TMR_N);

    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] REP_LAST  = TMR_W'(REPEAT_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             stable;
    logic [DB_W-1:0]  db_cnt;

    // Repeat FSM state; kept as a named register so checkers can bind to it.
    step_state_t      state;
    step_state_t      state_next;
    logic [TMR_W-1:0] timer;
    logic [TMR_W-1:0] timer_next;
    logic             step_next;

    // Two-flop synchroniser and debounce: accept a change only after it has held long enough.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 2'b11;
            stable <= 1'b1;
            db_cnt <= '0;
        end else begin
            sync_q <= {sync_q[0], key_n};
            if (sync_q[1] != stable) begin
                if (db_cnt == DB_LAST) begin
                    stable <= sync_q[1];
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    // Repeat FSM registers; the step output is a registered one-cycle pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            timer <= '0;
            step  <= 1'b0;
        end else begin
            state <= state_next;
            timer <= timer_next;
            step  <= step_next;
        end
    end

    // Next state: step on press, again after the hold time, then every repeat period.
    always_comb begin
        state_next = state;
        timer_next = timer;
        step_next  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!stable) begin
                    state_next = ST_HELD;
                    timer_next = '0;
                    step_next  = 1'b1;
                end
            end
            ST_HELD: begin
                if (stable) begin
                    state_next = ST_IDLE;
                end else if (HOLD_CYCLES != 0) begin
                    if (timer == HOLD_LAST) begin
                        state_next = ST_REPEAT;
                        timer_next = '0;
                        step_next  = 1'b1;
                    end else begin
                        timer_next = timer + 1'b1;
                    end
                end
            end
            ST_REPEAT: begin
                if (stable) begin
                    state_next = ST_IDLE;
                end else if (timer == REP_LAST) begin
                    timer_next = '0;
                    step_next  = 1'b1;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                timer_next = '0;
            end
        endcase
    end

endmodule

// File: rtl/key_counter_bank.sv
// Bank of independent up/down counters driven by debounced, auto-repeating board keys.
module key_counter_bank
    import key_counter_bank_pkg::*;
#(
    parameter int N_CH            = 2,
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50_000,
    parameter int HOLD_CYCLES     = 25_000_000,
    parameter int REPEAT_CYCLES   = 5_000_000,
    parameter int SATURATE        = SAT_WRAP
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_CH-1:0]       key_inc_n,
    input  logic [N_CH-1:0]       key_dec_n,
    input  logic [N_CH-1:0]       clr,
    output logic [N_CH*WIDTH-1:0] count,
    output logic [N_CH-1:0]       at_max,
    output logic [N_CH-1:0]       at_min,
    output logic [N_CH-1:0]       wrap
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic [N_CH-1:0] inc_step;
    logic [N_CH-1:0] dec_step;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [WIDTH-1:0] cnt_q;
        logic             wrap_q;

        key_step_gen #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .HOLD_CYCLES    (HOLD_CYCLES),
            .REPEAT_CYCLES  (REPEAT_CYCLES)
        ) u_inc (
            .clk  (clk),
            .reset(reset),
            .key_n(key_inc_n[c]),
            .step (inc_step[c])
        );

        key_step_gen #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .HOLD_CYCLES    (HOLD_CYCLES),
            .REPEAT_CYCLES  (REPEAT_CYCLES)
        ) u_dec (
            .clk  (clk),
            .reset(reset),
            .key_n(key_dec_n[c]),
            .step (dec_step[c])
        );

        // Counter update: clear wins, opposing steps cancel, otherwise step with wrap or clamp.
        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q  <= '0;
                wrap_q <= 1'b0;
            end else begin
                wrap_q <= 1'b0;
                if (clr[c]) begin
                    cnt_q <= '0;
                end else if (inc_step[c] && dec_step[c]) begin
                    cnt_q <= cnt_q;
                end else if (inc_step[c]) begin
                    if (cnt_q == CNT_MAX) begin
                        if (SATURATE != SAT_CLAMP) begin
                            cnt_q  <= '0;
                            wrap_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end else if (dec_step[c]) begin
                    if (cnt_q == '0) begin
                        if (SATURATE != SAT_CLAMP) begin
                            cnt_q  <= CNT_MAX;
                            wrap_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
            end
        end

        assign count[c*WIDTH +: WIDTH] = cnt_q;
        assign at_max[c]               = (cnt_q == CNT_MAX);
        assign at_min[c]               = (cnt_q == '0);
        assign wrap[c]                 = wrap_q;
    end

endmodule

// File: tb/tb_key_counter_bank.sv
// Bench for key_counter_bank: a wrapping and a saturating instance share all stimulus.
module tb_key_counter_bank;

  localparam int N_CH  = 2;
  localparam int WIDTH = 4;
  localparam int D     = 4;
  localparam int HOLD  = 10;
  localparam int REP   = 3;
  localparam int MAXV  = 15;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic [N_CH-1:0] key_inc_n;
  logic [N_CH-1:0] key_dec_n;
  logic [N_CH-1:0] clr;
  logic [N_CH*WIDTH-1:0] count_w, count_s;
  logic [N_CH-1:0] at_max_w, at_min_w, wrap_w;
  logic [N_CH-1:0] at_max_s, at_min_s, wrap_s;

  always #5 clk = ~clk;

  key_counter_bank #(
    .N_CH(N_CH), .WIDTH(WIDTH), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(HOLD),
    .REPEAT_CYCLES(REP), .SATURATE(0)
  ) dut_w (
    .clk(clk), .reset(reset), .key_inc_n(key_inc_n), .key_dec_n(key_dec_n), .clr(clr),
    .count(count_w), .at_max(at_max_w), .at_min(at_min_w), .wrap(wrap_w)
  );

  key_counter_bank #(
    .N_CH(N_CH), .WIDTH(WIDTH), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(HOLD),
    .REPEAT_CYCLES(REP), .SATURATE(1)
  ) dut_s (
    .clk(clk), .reset(reset), .key_inc_n(key_inc_n), .key_dec_n(key_dec_n), .clr(clr),
    .count(count_s), .at_max(at_max_s), .at_min(at_min_s), .wrap(wrap_s)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Keys 0..1 are inc for ch0..1, keys 2..3 are dec for ch0..1.
  // A key is accepted after D consecutive cycles of disagreement with the accepted level;
  // while accepted-pressed, "age" counts cycles since the press and steps fall at
  // age 0, age HOLD and every REP cycles after that.
  int m_s0[4];
  int m_s1[4];
  int m_stable[4];
  int m_run[4];
  int m_age[4];
  bit m_step[4];
  int m_cnt[2][2];
  bit m_wrap[2][2];

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_s0[k] = 1; m_s1[k] = 1; m_stable[k] = 1;
      m_run[k] = 0; m_age[k] = -1; m_step[k] = 1'b0;
    end
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 2; c++) begin
        m_cnt[d][c] = 0;
        m_wrap[d][c] = 1'b0;
      end
  endtask

  task automatic model_edge();
    bit old_step[4];
    int raw[4];
    old_step = m_step;
    for (int k = 0; k < 4; k++)
      raw[k] = (k < 2) ? int'(key_inc_n[k]) : int'(key_dec_n[k-2]);
    for (int k = 0; k < 4; k++) begin
      int old_stable;
      int old_s1;
      old_stable = m_stable[k];
      old_s1 = m_s1[k];
      if (old_stable == 0) begin
        m_age[k] = (m_age[k] < 0) ? 0 : m_age[k] + 1;
        m_step[k] = (m_age[k] == 0) ||
                    (HOLD > 0 && m_age[k] >= HOLD && ((m_age[k] - HOLD) % REP) == 0);
      end else begin
        m_age[k] = -1;
        m_step[k] = 1'b0;
      end
      if (old_s1 != old_stable) begin
        m_run[k]++;
        if (m_run[k] == D) begin
          m_stable[k] = old_s1;
          m_run[k] = 0;
        end
      end else begin
        m_run[k] = 0;
      end
      m_s1[k] = m_s0[k];
      m_s0[k] = raw[k];
    end
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 2; c++) begin
        bit inc;
        bit dec;
        inc = old_step[c];
        dec = old_step[c+2];
        m_wrap[d][c] = 1'b0;
        if (clr[c]) m_cnt[d][c] = 0;
        else if (inc && dec) m_cnt[d][c] = m_cnt[d][c];
        else if (inc) begin
          if (m_cnt[d][c] == MAXV) begin
            if (d == 0) begin m_cnt[d][c] = 0; m_wrap[d][c] = 1'b1; end
          end else m_cnt[d][c] = m_cnt[d][c] + 1;
        end else if (dec) begin
          if (m_cnt[d][c] == 0) begin
            if (d == 0) begin m_cnt[d][c] = MAXV; m_wrap[d][c] = 1'b1; end
          end else m_cnt[d][c] = m_cnt[d][c] - 1;
        end
      end
  endtask

  task automatic check_outputs();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 2; c++) begin
        logic [WIDTH-1:0] a_cnt;
        logic a_wrap, a_max, a_min;
        a_cnt  = (d == 0) ? count_w[c*WIDTH +: WIDTH] : count_s[c*WIDTH +: WIDTH];
        a_wrap = (d == 0) ? wrap_w[c] : wrap_s[c];
        a_max  = (d == 0) ? at_max_w[c] : at_max_s[c];
        a_min  = (d == 0) ? at_min_w[c] : at_min_s[c];
        chk($sformatf("model_count_d%0d_ch%0d", d, c), int'(a_cnt), m_cnt[d][c]);
        chk($sformatf("model_wrap_d%0d_ch%0d", d, c), int'(a_wrap), int'(m_wrap[d][c]));
        chk($sformatf("model_atmax_d%0d_ch%0d", d, c), int'(a_max), int'(m_cnt[d][c] == MAXV));
        chk($sformatf("model_atmin_d%0d_ch%0d", d, c), int'(a_min), int'(m_cnt[d][c] == 0));
      end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else model_edge();
    #1;
    check_outputs();
  endtask

  task automatic release_all();
    key_inc_n = '1;
    key_dec_n = '1;
    clr = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    release_all();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    release_all();
    repeat (n) tick();
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic [1:0] inc_n;
    logic [1:0] dec_n;
    logic [1:0] clr_v;
    int hold;
    int exp_w0;
    int exp_s0;
    int exp_c1;
    logic exp_max_s0;
    logic exp_min_s0;
  } vec_t;

  vec_t tbl[9];

  initial begin
    model_reset();
    reset = 1'b1;
    release_all();

    // Reset state.
    do_reset();
    chk("reset_count_w", int'(count_w), 0);
    chk("reset_count_s", int'(count_s), 0);
    chk("reset_wrap", int'(wrap_w), 0);
    chk("reset_at_min", int'(at_min_w), 3);

    // First press latency: key sampled from edge 1, count moves at edge D+4.
    key_inc_n[0] = 1'b0;
    repeat (6) tick();
    key_inc_n[0] = 1'b1;
    tick();
    chk("lat_edge7_count0", int'(count_w[3:0]), 0);
    tick();
    chk("lat_edge8_count0", int'(count_w[3:0]), 1);
    chk("lat_edge8_count1", int'(count_w[7:4]), 0);
    idle(16);
    chk("single_step_count0", int'(count_w[3:0]), 1);

    // Bounce shorter than the debounce window produces no step.
    key_inc_n[0] = 1'b0; repeat (2) tick();
    key_inc_n[0] = 1'b1; tick();
    key_inc_n[0] = 1'b0; repeat (2) tick();
    idle(16);
    chk("bounce_count0_w", int'(count_w[3:0]), 1);
    chk("bounce_count0_s", int'(count_s[3:0]), 1);

    // Table: press pattern held for 'hold' cycles, then released long enough to settle.
    tbl[0] = '{2'b10, 2'b11, 2'b00, 6,  1,  1,  0, 1'b0, 1'b0};
    tbl[1] = '{2'b11, 2'b10, 2'b00, 6,  0,  0,  0, 1'b0, 1'b1};
    tbl[2] = '{2'b11, 2'b10, 2'b00, 6,  15, 0,  0, 1'b0, 1'b1};
    tbl[3] = '{2'b10, 2'b11, 2'b00, 6,  0,  1,  0, 1'b0, 1'b0};
    tbl[4] = '{2'b10, 2'b11, 2'b00, 80, 9,  15, 0, 1'b1, 1'b0};
    tbl[5] = '{2'b10, 2'b11, 2'b00, 6,  10, 15, 0, 1'b1, 1'b0};
    tbl[6] = '{2'b01, 2'b11, 2'b00, 40, 10, 15, 11, 1'b1, 1'b0};
    tbl[7] = '{2'b11, 2'b01, 2'b00, 6,  10, 15, 10, 1'b1, 1'b0};
    tbl[8] = '{2'b11, 2'b11, 2'b11, 1,  0,  0,  0, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      key_inc_n = tbl[i].inc_n;
      key_dec_n = tbl[i].dec_n;
      clr = tbl[i].clr_v;
      repeat (tbl[i].hold) tick();
      idle(16);
      chk($sformatf("tbl%0d_count0_w", i), int'(count_w[3:0]), tbl[i].exp_w0);
      chk($sformatf("tbl%0d_count0_s", i), int'(count_s[3:0]), tbl[i].exp_s0);
      chk($sformatf("tbl%0d_count1_w", i), int'(count_w[7:4]), tbl[i].exp_c1);
      chk($sformatf("tbl%0d_count1_s", i), int'(count_s[7:4]), tbl[i].exp_c1);
      chk($sformatf("tbl%0d_atmax_s0", i), int'(at_max_s[0]), int'(tbl[i].exp_max_s0));
      chk($sformatf("tbl%0d_atmin_s0", i), int'(at_min_s[0]), int'(tbl[i].exp_min_s0));
    end

    // Simultaneous inc and dec on ch0 cancel.
    key_inc_n[0] = 1'b0;
    key_dec_n[0] = 1'b0;
    repeat (6) tick();
    idle(16);
    chk("incdec_cancel_count0", int'(count_w[3:0]), 0);

    // Clear on the cycle a step lands drops the step.
    key_inc_n[0] = 1'b0; repeat (6) tick();
    idle(16);
    chk("pre_clr_count0", int'(count_w[3:0]), 1);
    key_inc_n[0] = 1'b0;
    repeat (6) tick();
    key_inc_n[0] = 1'b1;
    tick();
    clr[0] = 1'b1;
    tick();
    clr[0] = 1'b0;
    chk("clr_with_step_count0", int'(count_w[3:0]), 0);
    idle(16);
    chk("clr_with_step_after", int'(count_w[3:0]), 0);

    // Reset while auto-repeating; key stays held and must be re-debounced.
    key_inc_n[1] = 1'b0;
    repeat (30) tick();
    chk("repeat_before_reset", int'(count_w[7:4]), 6);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("repeat_reset_count1", int'(count_w[7:4]), 0);
    repeat (7) tick();
    chk("rearm_no_step_yet", int'(count_w[7:4]), 0);
    tick();
    chk("rearm_new_press", int'(count_w[7:4]), 1);
    idle(16);

    // Randomised stimulus against the model.
    for (int seg = 0; seg < 80; seg++) begin
      int n;
      key_inc_n = 2'($urandom);
      key_dec_n = 2'($urandom);
      n = $urandom_range(1, 40);
      reset = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < n; i++) begin
        clr = ($urandom_range(0, 19) == 0) ? 2'($urandom) : 2'b00;
        tick();
        reset = 1'b0;
      end
    end
    idle(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
